// File: rtl/fdiv_if.sv
// Operand/result handshake bundle between the FPU issue/writeback path and fdiv_pipe.
interface fdiv_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output in_valid, x1, x2, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, x1, x2, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fdiv_pipe.sv
// Pipelined single-precision divider q = x1 * finv(x2), with a credit-controlled
// result FIFO so the free-running reciprocal pipe never needs to stall.

// Free-running 3-cycle reciprocal: truncated 1/x with denormal results flushed to zero.
module finv (
    input  logic        clk,
    input  logic [31:0] x,
    output logic [31:0] y
);
    // Eight steps of restoring long division; r_in < d on entry.
    function automatic logic [31:0] div8(input logic [23:0] r_in, input logic [23:0] d);
        logic [24:0] r;
        logic [7:0]  q;
        r = {1'b0, r_in};
        q = '0;
        for (int i = 7; i >= 0; i--) begin
            r = {r[23:0], 1'b0};
            if (r >= {1'b0, d}) begin
                q[i] = 1'b1;
                r    = r - {1'b0, d};
            end
        end
        return {q, r[23:0]};
    endfunction

    logic [23:0] d1, r1, d2, r2;
    logic [7:0]  q1a, q2a, q2b;
    logic        s1, s2, m0_1, m0_2;
    logic [7:0]  e1, e2;
    logic [7:0]  q3;
    logic [23:0] r3_unused;
    logic [23:0] q_full;
    logic signed [9:0] ex;
    logic [31:0] y_nxt;

    // Numerator is 2^47; starting the partial remainder at 2^23 yields quotient bit 23 first.
    always_ff @(posedge clk) begin
        {q1a, r1} <= div8(24'h800000, {1'b1, x[22:0]});
        d1        <= {1'b1, x[22:0]};
        s1        <= x[31];
        e1        <= x[30:23];
        m0_1      <= (x[22:0] == 23'h0);

        {q2b, r2} <= div8(r1, d1);
        q2a       <= q1a;
        d2        <= d1;
        s2        <= s1;
        e2        <= e1;
        m0_2      <= m0_1;

        y         <= y_nxt;
    end

    always_comb begin
        {q3, r3_unused} = div8(r2, d2);
        q_full = {q2a, q2b, q3};
        ex     = (m0_2 ? 10'sd254 : 10'sd253) - $signed({2'b00, e2});
        y_nxt  = {s2, ex[7:0], q_full[22:0]};
        if (e2 == 8'h0)
            y_nxt = {s2, 8'hFF, 23'h0};
        else if (ex <= 10'sd0)
            y_nxt = {s2, 31'h0};
        else if (m0_2)
            y_nxt = {s2, ex[7:0], 23'h0};
    end
endmodule

module fdiv_pipe #(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rstn,
    fdiv_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] inv;
    logic        accept;

    finv u_finv (
        .clk (clk),
        .x   (bus.x2),
        .y   (inv)
    );

    assign accept = bus.in_valid && bus.in_ready;

    // x1 and the x2-zero flag ride alongside finv's three stages.
    logic [2:0]  v_d;
    logic [2:0]  z2_d;
    logic [31:0] x1_d [3];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            v_d <= '0;
        else
            v_d <= {v_d[1:0], accept};
    end

    always_ff @(posedge clk) begin
        x1_d[0] <= bus.x1;
        x1_d[1] <= x1_d[0];
        x1_d[2] <= x1_d[1];
        z2_d    <= {z2_d[1:0], (bus.x2[30:23] == 8'h0)};
    end

    // Stage A: sign, full mantissa product and unnormalised exponent.
    logic [24:0]       p_hi;
    logic [22:0]       p_lo_unused;
    logic              a_v;
    logic              a_s;
    logic [24:0]       a_p;
    logic signed [9:0] a_e;
    logic              a_z1;
    logic              a_z2;

    assign {p_hi, p_lo_unused} = 48'({1'b1, x1_d[2][22:0]}) * 48'({1'b1, inv[22:0]});

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            a_v <= 1'b0;
        else
            a_v <= v_d[2];
    end

    always_ff @(posedge clk) begin
        a_s  <= x1_d[2][31] ^ inv[31];
        a_p  <= p_hi;
        a_e  <= $signed({2'b00, x1_d[2][30:23]}) + $signed({2'b00, inv[30:23]}) - 10'sd127;
        a_z1 <= (x1_d[2][30:23] == 8'h0);
        a_z2 <= z2_d[2];
    end

    // Stage B: normalise, truncate, apply special cases; result goes straight into the FIFO.
    logic signed [9:0] b_e;
    logic [22:0]       b_mant;
    logic [31:0]       b_res;

    always_comb begin
        b_e    = a_e;
        b_mant = a_p[22:0];
        if (a_p[24]) begin
            b_mant = a_p[23:1];
            b_e    = a_e + 10'sd1;
        end
        b_res = {a_s, b_e[7:0], b_mant};
        if (a_z2)
            b_res = {a_s, 8'hFF, 23'h0};
        else if (a_z1 || (b_e <= 10'sd0))
            b_res = {a_s, 31'h0};
        else if (b_e >= 10'sd255)
            b_res = {a_s, 8'hFF, 23'h0};
    end

    // Result FIFO; every accepted op already holds a reserved slot.
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign push = a_v;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= b_res;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    int unsigned inflight;
    int unsigned occupancy;

    always_comb begin
        inflight  = 32'(v_d[0]) + 32'(v_d[1]) + 32'(v_d[2]) + 32'(a_v);
        occupancy = 32'(count) + inflight;
    end

    assign bus.in_ready  = (occupancy < 32'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign bus.out_data  = mem[rd_ptr];
endmodule
